// File: rtl/midi_con_pkg.sv
// Shared constants and state types for the MIDI con-bus UART.
package midi_con_pkg;

   // Register addresses
   localparam int unsigned REG_RXDATA  = 0;
   localparam int unsigned REG_TXDATA  = 1;
   localparam int unsigned REG_STATUS  = 2;
   localparam int unsigned REG_CONTROL = 3;
   localparam int unsigned REG_RXCOUNT = 4;

   // STATUS bit indices
   localparam int unsigned ST_RX_AVAIL    = 0;
   localparam int unsigned ST_TX_READY    = 1;
   localparam int unsigned ST_RX_OVERRUN  = 2;
   localparam int unsigned ST_FRAMING_ERR = 3;
   localparam int unsigned ST_RX_FULL     = 4;
   localparam int unsigned ST_TX_BUSY     = 5;

   // CONTROL bit indices
   localparam int unsigned CTL_RX_IRQ_EN = 0;
   localparam int unsigned CTL_TX_IRQ_EN = 1;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/midi_con_fifo.sv
// Synchronous FIFO; a pop in the same cycle frees a slot for a push when full.
module midi_con_fifo #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_c,
   output logic             full_c,
   output logic             empty_c,
   output logic             drop_c,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok_c;
   logic             push_ok_c;

   assign empty_c   = (count_q == '0);
   assign full_c    = (count_q == CNT_W'(DEPTH));
   assign pop_ok_c  = pop & ~empty_c;
   assign push_ok_c = push & (~full_c | pop_ok_c);
   assign drop_c    = push & ~push_ok_c;
   assign head_c    = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Next pointer, occupancy and storage
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_c) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy gates every read of it
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/midi_con_uart.sv
// MIDI UART behind the con register bus: RX FIFO, TX holding + shifter, IRQ.
module midi_con_uart
   import midi_con_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 3,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned BAUD          = 31_250,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     con_chip_sel,
   input  logic                     con_read,
   input  logic                     con_write,
   input  logic [ADDRESS_WIDTH-1:0] con_adr,
   input  logic [DATA_WIDTH-1:0]    con_wdata,
   output logic [DATA_WIDTH-1:0]    con_rdata,
   output logic                     con_int_n,
   input  logic                     midi_rxd,
   output logic                     midi_txd
);

   localparam int unsigned DIV      = CLK_HZ / BAUD;
   localparam int unsigned HALF_DIV = DIV / 2;
   localparam int unsigned CNT_W    = $clog2(DIV + 1);
   localparam int unsigned FCNT_W   = $clog2(FIFO_DEPTH) + 1;

   // Bus decode
   logic       acc_rd_c, acc_wr_c;
   logic       adr_rx_c, adr_tx_c, adr_st_c, adr_ctl_c, adr_cnt_c;
   logic [7:0] wdata8_c;
   logic       pop_c, tx_load_c, w1c_c;

   // Register state
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  int_n_q, int_n_d;
   logic [1:0]            ctrl_q, ctrl_d;
   logic                  overrun_q, overrun_d;
   logic                  framing_q, framing_d;
   logic [7:0]            status_c, rd8_c;

   // RX state
   logic                  rxd_s1_q, rxd_s2_q, rxd_prev_q;
   rx_state_e             rx_state_q, rx_state_d;
   logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
   logic [2:0]            rx_bit_q, rx_bit_d;
   logic [7:0]            rx_shift_q, rx_shift_d;
   logic                  rx_push_c, rx_ferr_c;

   // TX state
   tx_state_e             tx_state_q, tx_state_d;
   logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
   logic [2:0]            tx_bit_q, tx_bit_d;
   logic [7:0]            tx_shift_q, tx_shift_d;
   logic [7:0]            hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  txd_q, txd_d;

   // FIFO interface
   logic [7:0]            fifo_head_c;
   logic                  fifo_full_c, fifo_empty_c, fifo_drop_c;
   logic [FCNT_W-1:0]     fifo_count;

   assign acc_rd_c  = con_chip_sel & con_read;
   assign acc_wr_c  = con_chip_sel & con_write & ~con_read;
   assign wdata8_c  = 8'(con_wdata);
   assign adr_rx_c  = (con_adr == ADDRESS_WIDTH'(REG_RXDATA));
   assign adr_tx_c  = (con_adr == ADDRESS_WIDTH'(REG_TXDATA));
   assign adr_st_c  = (con_adr == ADDRESS_WIDTH'(REG_STATUS));
   assign adr_ctl_c = (con_adr == ADDRESS_WIDTH'(REG_CONTROL));
   assign adr_cnt_c = (con_adr == ADDRESS_WIDTH'(REG_RXCOUNT));
   assign pop_c     = acc_rd_c & adr_rx_c;
   assign tx_load_c = acc_wr_c & adr_tx_c & ~hold_full_q;
   assign w1c_c     = acc_wr_c & adr_st_c;

   midi_con_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (rx_push_c),
      .push_data (rx_shift_q),
      .pop       (pop_c),
      .head_c    (fifo_head_c),
      .full_c    (fifo_full_c),
      .empty_c   (fifo_empty_c),
      .drop_c    (fifo_drop_c),
      .count     (fifo_count)
   );

   // RX deserialiser: mid-bit sampling off the synchronised line
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push_c  = 1'b0;
      rx_ferr_c  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rxd_prev_q & ~rxd_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == CNT_W'(HALF_DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_W'(DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_W'(DIV - 1)) begin
               rx_cnt_d = '0;
               if (rxd_s2_q) begin
                  rx_push_c  = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_ferr_c  = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         RX_WAIT_HIGH: begin
            if (rxd_s2_q) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // TX serialiser; STOP chains straight into the next START when a byte waits
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      txd_d       = txd_q;
      if (tx_load_c) begin
         hold_d      = wdata8_c;
         hold_full_d = 1'b1;
      end
      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (hold_full_q) begin
               tx_shift_d  = hold_q;
               hold_full_d = 1'b0;
               tx_cnt_d    = '0;
               tx_state_d  = TX_START;
               txd_d       = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_W'(DIV - 1)) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
               txd_d      = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_W'(DIV - 1)) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  txd_d      = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == CNT_W'(DIV - 1)) begin
               tx_cnt_d = '0;
               if (hold_full_q) begin
                  tx_shift_d  = hold_q;
                  hold_full_d = 1'b0;
                  tx_state_d  = TX_START;
                  txd_d       = 1'b0;
               end else begin
                  tx_state_d = TX_IDLE;
                  txd_d      = 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Register file, sticky flags, read mux and interrupt
   always_comb begin
      status_c                 = '0;
      status_c[ST_RX_AVAIL]    = ~fifo_empty_c;
      status_c[ST_TX_READY]    = ~hold_full_q;
      status_c[ST_RX_OVERRUN]  = overrun_q;
      status_c[ST_FRAMING_ERR] = framing_q;
      status_c[ST_RX_FULL]     = fifo_full_c;
      status_c[ST_TX_BUSY]     = (tx_state_q != TX_IDLE);

      rd8_c = 8'h00;
      if (adr_rx_c) begin
         rd8_c = fifo_empty_c ? 8'h00 : fifo_head_c;
      end else if (adr_st_c) begin
         rd8_c = status_c;
      end else if (adr_ctl_c) begin
         rd8_c = {6'b0, ctrl_q};
      end else if (adr_cnt_c) begin
         rd8_c = 8'(fifo_count);
      end

      rdata_d = rdata_q;
      if (acc_rd_c) begin
         rdata_d = DATA_WIDTH'(rd8_c);
      end

      ctrl_d = ctrl_q;
      if (acc_wr_c & adr_ctl_c) begin
         ctrl_d = wdata8_c[1:0];
      end

      // Clear first so a same-cycle set wins
      overrun_d = overrun_q;
      framing_d = framing_q;
      if (w1c_c & wdata8_c[ST_RX_OVERRUN]) overrun_d = 1'b0;
      if (w1c_c & wdata8_c[ST_FRAMING_ERR]) framing_d = 1'b0;
      if (fifo_drop_c) overrun_d = 1'b1;
      if (rx_ferr_c) framing_d = 1'b1;

      int_n_d = ~((ctrl_q[CTL_RX_IRQ_EN] & ~fifo_empty_c) |
                  (ctrl_q[CTL_TX_IRQ_EN] & ~hold_full_q) |
                  overrun_q | framing_q);
   end

   // All state registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rxd_s1_q    <= 1'b1;
         rxd_s2_q    <= 1'b1;
         rxd_prev_q  <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         txd_q       <= 1'b1;
         rdata_q     <= '0;
         int_n_q     <= 1'b1;
         ctrl_q      <= '0;
         overrun_q   <= 1'b0;
         framing_q   <= 1'b0;
      end else begin
         rxd_s1_q    <= midi_rxd;
         rxd_s2_q    <= rxd_s1_q;
         rxd_prev_q  <= rxd_s2_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         txd_q       <= txd_d;
         rdata_q     <= rdata_d;
         int_n_q     <= int_n_d;
         ctrl_q      <= ctrl_d;
         overrun_q   <= overrun_d;
         framing_q   <= framing_d;
      end
   end

   assign con_rdata = rdata_q;
   assign con_int_n = int_n_q;
   assign midi_txd  = txd_q;

endmodule

// File: tb/tb_midi_con_uart.sv
// Self-checking bench for midi_con_uart with a queue-based receive model.
`timescale 1ns/1ps
module tb_midi_con_uart;

   localparam int unsigned CLK_HZ = 500_000;
   localparam int unsigned BAUD   = 31_250;
   localparam int unsigned DIV    = CLK_HZ / BAUD;
   localparam int unsigned DEPTH  = 16;

   localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_CTL = 3'd3, A_CNT = 3'd4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       con_chip_sel, con_read, con_write;
   logic [2:0] con_adr;
   logic [7:0] con_wdata;
   logic [7:0] con_rdata;
   logic       con_int_n;
   logic       midi_rxd;
   logic       midi_txd;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Receive model: bytes the bench expects in the FIFO plus sticky flags
   logic [7:0] mq[$];
   logic       m_ov, m_fe;

   // TX line monitor results
   logic [7:0] tx_q[$];
   int         tx_t[$];
   int         tx_stop_err = 0;
   logic       mon_en = 1'b0;

   typedef struct {
      logic       sel;
      logic       rd;
      logic       wr;
      logic [2:0] adr;
      logic [7:0] wd;
      logic       chk;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[18];

   midi_con_uart #(
      .ADDRESS_WIDTH (3),
      .DATA_WIDTH    (8),
      .CLK_HZ        (CLK_HZ),
      .BAUD          (BAUD),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .con_chip_sel (con_chip_sel),
      .con_read     (con_read),
      .con_write    (con_write),
      .con_adr      (con_adr),
      .con_wdata    (con_wdata),
      .con_rdata    (con_rdata),
      .con_int_n    (con_int_n),
      .midi_rxd     (midi_rxd),
      .midi_txd     (midi_txd)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   function automatic vec_t mk(input logic sel, input logic rd, input logic wr, input logic [2:0] adr,
                               input logic [7:0] wd, input logic chk, input logic [7:0] exp);
      vec_t v;
      v.sel = sel; v.rd = rd; v.wr = wr; v.adr = adr; v.wd = wd; v.chk = chk; v.exp = exp;
      return v;
   endfunction

   function automatic logic [7:0] m_status();
      return {3'b000, (mq.size() == DEPTH), m_fe, m_ov, 1'b1, (mq.size() != 0)};
   endfunction

   // One bus cycle, called and returning at a negedge
   task automatic bus_access(input logic sel, input logic rd, input logic wr,
                             input logic [2:0] a, input logic [7:0] wd);
      con_chip_sel = sel; con_read = rd; con_write = wr; con_adr = a; con_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      con_chip_sel = 1'b0; con_read = 1'b0; con_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      bus_access(1'b1, 1'b1, 1'b0, a, 8'h00);
      d = con_rdata;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      bus_access(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         midi_rxd = f[i];
         repeat (DIV) @(negedge clk);
      end
      midi_rxd = 1'b1;
   endtask

   // Frame plus idle gap, updating the model from the line-level rules
   task automatic rx_frame_model(input logic [7:0] b, input logic stop);
      send_frame(b, stop);
      repeat (2 * DIV) @(negedge clk);
      if (!stop) m_fe = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else m_ov = 1'b1;
   endtask

   task automatic pop_check(input string name);
      logic [7:0] d, e;
      e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
      bus_read(A_RX, d);
      check(name, d, e);
   endtask

   // MIDI OUT decoder: samples each bit at its centre
   initial begin
      logic [7:0] v;
      int st;
      forever begin
         @(negedge clk);
         if (mon_en && midi_txd == 1'b0) begin
            st = cyc;
            repeat (DIV / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (DIV) @(negedge clk);
               v[b] = midi_txd;
            end
            repeat (DIV) @(negedge clk);
            if (midi_txd !== 1'b1) tx_stop_err++;
            tx_q.push_back(v);
            tx_t.push_back(st);
         end
      end
   end

   initial begin
      logic [7:0] d, b;
      logic       prev_int, found, stop;
      int         t_s, t_av, cyc_w, cnt;

      con_chip_sel = 1'b0; con_read = 1'b0; con_write = 1'b0;
      con_adr = 3'd0; con_wdata = 8'h00; midi_rxd = 1'b1;
      m_ov = 1'b0; m_fe = 1'b0;

      vecs[0]  = mk(1, 1, 0, A_ST,  8'h00, 1, 8'h02);
      vecs[1]  = mk(1, 0, 1, A_CTL, 8'h03, 1, 8'h02);
      vecs[2]  = mk(1, 1, 0, A_CTL, 8'h00, 1, 8'h03);
      vecs[3]  = mk(0, 0, 1, A_CTL, 8'h00, 0, 8'h00);
      vecs[4]  = mk(1, 1, 0, A_CTL, 8'h00, 1, 8'h03);
      vecs[5]  = mk(1, 1, 1, A_CTL, 8'h00, 1, 8'h03);
      vecs[6]  = mk(1, 1, 0, A_CTL, 8'h00, 1, 8'h03);
      vecs[7]  = mk(1, 0, 1, A_CTL, 8'hFC, 0, 8'h00);
      vecs[8]  = mk(1, 1, 0, A_CTL, 8'h00, 1, 8'h00);
      vecs[9]  = mk(1, 1, 0, A_CNT, 8'h00, 1, 8'h00);
      vecs[10] = mk(1, 1, 0, A_RX,  8'h00, 1, 8'h00);
      vecs[11] = mk(1, 1, 0, A_TX,  8'h00, 1, 8'h00);
      vecs[12] = mk(1, 0, 1, 3'd7,  8'hFF, 0, 8'h00);
      vecs[13] = mk(1, 1, 0, 3'd7,  8'h00, 1, 8'h00);
      vecs[14] = mk(1, 1, 0, 3'd5,  8'h00, 1, 8'h00);
      vecs[15] = mk(1, 1, 0, 3'd6,  8'h00, 1, 8'h00);
      vecs[16] = mk(1, 1, 0, A_ST,  8'h00, 1, 8'h02);
      vecs[17] = mk(0, 1, 0, A_CTL, 8'h00, 1, 8'h02);

      // Reset
      reset_n = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_rdata", con_rdata, 8'h00);
      check("reset_int_n", con_int_n, 1'b1);
      check("reset_txd", midi_txd, 1'b1);

      // Register access table
      for (int i = 0; i < 18; i++) begin
         bus_access(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wd);
         if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), con_rdata, vecs[i].exp);
      end

      // Single frame 0x90
      rx_frame_model(8'h90, 1'b1);
      bus_read(A_CNT, d);
      check("rx90_count1", d, 8'd1);
      pop_check("rx90_data");
      bus_read(A_CNT, d);
      check("rx90_count0", d, 8'd0);
      bus_read(A_ST, d);
      check("rx90_avail_clear", d[0], 1'b0);

      // RX interrupt timing and rx_avail latency
      bus_write(A_CTL, 8'h01);
      @(negedge clk);
      check("irq_idle_high", con_int_n, 1'b1);
      t_s = cyc; t_av = 0; found = 1'b0; prev_int = 1'b1;
      fork
         send_frame(8'h45, 1'b1);
         begin
            for (int i = 0; i < 12 * DIV && !found; i++) begin
               bus_read(A_ST, d);
               if (d[0]) begin
                  found = 1'b1;
                  t_av  = cyc;
                  check("irq_low_after_avail", con_int_n, 1'b0);
                  check("irq_high_before_avail", prev_int, 1'b1);
               end else begin
                  prev_int = con_int_n;
               end
            end
         end
      join
      check("irq_avail_seen", found, 1'b1);
      check("rx_avail_latency", t_av - t_s, 3 + (19 * DIV) / 2 + 1);
      repeat (2 * DIV) @(negedge clk);
      bus_read(A_RX, d);
      check("irq_rxdata", d, 8'h45);
      check("irq_low_at_read", con_int_n, 1'b0);
      @(negedge clk);
      check("irq_high_after_read", con_int_n, 1'b1);
      bus_write(A_CTL, 8'h00);

      // Randomized frames, reads and W1C writes against the model
      for (int i = 0; i < 10; i++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         rx_frame_model(b, stop);
         if ($urandom_range(0, 1) == 1) pop_check($sformatf("rnd%0d_pop", i));
         if ($urandom_range(0, 2) == 0) begin
            d = 8'($urandom) & 8'h0C;
            bus_write(A_ST, d);
            if (d[2]) m_ov = 1'b0;
            if (d[3]) m_fe = 1'b0;
         end
         bus_read(A_ST, d);
         check($sformatf("rnd%0d_status", i), d, m_status());
         bus_read(A_CNT, d);
         check($sformatf("rnd%0d_count", i), d, 8'(mq.size()));
      end
      while (mq.size() != 0) pop_check("rnd_drain");
      bus_write(A_ST, 8'h0C);
      m_ov = 1'b0; m_fe = 1'b0;

      // Overrun: 17 bytes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) rx_frame_model(8'($urandom), 1'b1);
      bus_read(A_CNT, d);
      check("ovr_count", d, 8'(DEPTH));
      bus_read(A_ST, d);
      check("ovr_status", d, m_status());
      check("ovr_int_n", con_int_n, 1'b0);
      bus_write(A_ST, 8'h04);
      m_ov = 1'b0;
      bus_read(A_ST, d);
      check("ovr_w1c_status", d, m_status());
      check("ovr_w1c_int_n", con_int_n, 1'b1);
      for (int i = 0; i < 16; i++) pop_check($sformatf("ovr_pop%0d", i));
      bus_read(A_CNT, d);
      check("ovr_drained", d, 8'd0);

      // Framing error and glitch rejection
      rx_frame_model(8'hA5, 1'b0);
      bus_read(A_CNT, d);
      check("ferr_not_stored", d, 8'd0);
      bus_read(A_ST, d);
      check("ferr_status", d, m_status());
      bus_write(A_ST, 8'h08);
      m_fe = 1'b0;
      midi_rxd = 1'b0;
      repeat (DIV / 4) @(negedge clk);
      midi_rxd = 1'b1;
      repeat (12 * DIV) @(negedge clk);
      bus_read(A_CNT, d);
      check("glitch_count", d, 8'd0);
      bus_read(A_ST, d);
      check("glitch_status", d, 8'h02);

      // TX: 0x3C, 0x7F dropped while holding full, then 0x45 back-to-back
      mon_en = 1'b1;
      bus_write(A_TX, 8'h3C);
      cyc_w = cyc;
      bus_write(A_TX, 8'h7F);
      bus_read(A_ST, d);
      check("tx_status_busy_ready", d, 8'h22);
      bus_write(A_TX, 8'h45);
      bus_read(A_ST, d);
      check("tx_status_busy_full", d, 8'h20);
      cnt = 0;
      while (tx_q.size() < 2 && cnt < 25 * DIV) begin
         @(negedge clk);
         cnt++;
      end
      repeat (4 * DIV) @(negedge clk);
      check("tx_frame_count", tx_q.size(), 2);
      if (tx_q.size() >= 2) begin
         check("tx_byte0", tx_q[0], 8'h3C);
         check("tx_byte1", tx_q[1], 8'h45);
         check("tx_start_latency", tx_t[0] - cyc_w, 1);
         check("tx_back_to_back", tx_t[1] - tx_t[0], 10 * DIV);
      end
      check("tx_stop_bits", tx_stop_err, 0);
      check("tx_idle_high", midi_txd, 1'b1);
      bus_read(A_ST, d);
      check("tx_status_idle", d, 8'h02);

      // Reset in the middle of a TX frame
      mon_en = 1'b0;
      bus_write(A_TX, 8'h00);
      repeat (3 * DIV) @(negedge clk);
      check("tx_mid_low", midi_txd, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check("tx_reset_high", midi_txd, 1'b1);
      check("tx_reset_int_n", con_int_n, 1'b1);
      check("tx_reset_rdata", con_rdata, 8'h00);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(A_ST, d);
      check("post_reset_status", d, 8'h02);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
